replicated_window_feeder: RTL and testbench

//   Input-side companion to the replicated stateful processor.
//   - Accepts a single-byte valid/ready stream, for example from the board UART receiver.
//   - Assembles a sliding window of REPLICATION_FACTOR bytes and drives it to the processor.
//   - Pulses the processor enable once per new byte after the window has filled.
//   - Captures each processor result byte into an output FIFO, presented as a valid/ready

---
 rtl/replicated_window_feeder.sv | 174 +++++++++++++++++
 tb/tb_replicated_window_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replicated_window_feeder.sv
// Byte-stream front end for the replicated processor: builds a sliding R-byte window,
// pulses step per processed window and queues result bytes in an output FIFO.
module replicated_window_feeder #(
    parameter int REPLICATION_FACTOR = 3,
    parameter int RESULT_DELAY       = 0,
    parameter int OUT_DEPTH          = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [7:0]                      in_byte,
    input  logic                            flush,
    output logic [8*REPLICATION_FACTOR-1:0] window,
    output logic                            step,
    input  logic [7:0]                      result_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [7:0]                      out_byte,
    output logic                            primed
);
    localparam int R     = REPLICATION_FACTOR;
    localparam int CNT_W = $clog2(R + 1);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int OCC_W = $clog2(OUT_DEPTH + RESULT_DELAY + 2) + 1;

    typedef enum logic {FILL, STREAM} fill_state_t;

    fill_state_t      state;
    fill_state_t      state_next;
    logic [CNT_W-1:0] fill_count;
    logic [CNT_W-1:0] fill_count_next;
    logic             started;
    logic             accept;
    logic             stream_accept;
    logic [8*R-1:0]   window_shifted;

    // One bit per processed window between its step cycle and its FIFO push.
    logic [RESULT_DELAY:0] flight;
    logic                  push;
    logic                  pop;

    logic [7:0]       fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] fifo_count;
    logic [OCC_W-1:0] outstanding;

    function automatic logic [OCC_W-1:0] count_ones(input logic [RESULT_DELAY:0] bits);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int k = 0; k <= RESULT_DELAY; k++) begin
            n = n + OCC_W'(bits[k]);
        end
        return n;
    endfunction

    // Every accepted STREAM byte reserves a FIFO slot until its result is popped.
    assign outstanding = fifo_count + count_ones(flight);

    always_comb begin
        in_ready = 1'b0;
        if (started && !flush) begin
            in_ready = (state == FILL) ? 1'b1 : (outstanding < OCC_W'(OUT_DEPTH));
        end
    end

    assign accept        = in_valid && in_ready;
    assign stream_accept = accept && ((state == STREAM) || (fill_count == CNT_W'(R - 1)));
    assign primed        = (state == STREAM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // ---- fill-state FSM ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            fill_count <= '0;
        end else begin
            state      <= state_next;
            fill_count <= fill_count_next;
        end
    end

    always_comb begin
        state_next      = state;
        fill_count_next = fill_count;
        if (flush) begin
            state_next      = FILL;
            fill_count_next = '0;
        end else if (accept && (state == FILL)) begin
            fill_count_next = fill_count + CNT_W'(1);
            if (fill_count == CNT_W'(R - 1)) begin
                state_next = STREAM;
            end
        end
    end

    // ---- window shift register ----
    generate
        if (R == 1) begin : g_single
            assign window_shifted = in_byte;
        end else begin : g_multi
            assign window_shifted = {window[8*R-9:0], in_byte};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window <= '0;
        end else if (flush) begin
            window <= '0;
        end else if (accept) begin
            window <= window_shifted;
        end
    end

    // ---- step / result-latency pipe ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flight <= '0;
        end else begin
            flight[0] <= stream_accept;
            for (int k = 1; k <= RESULT_DELAY; k++) begin
                flight[k] <= flight[k-1];
            end
        end
    end

    assign step = flight[0];
    assign push = flight[RESULT_DELAY];
    assign pop  = out_valid && out_ready;

    // ---- output FIFO ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= result_in;
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_byte  = out_valid ? fifo_mem[rd_ptr] : 8'h00;

    // Input throttling must make a push into a full, non-popping FIFO impossible.
    overflow_guard: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (fifo_count == OCC_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_replicated_window_feeder.sv
// Two feeders (result delay 0 and 2) on shared stimulus, each checked every cycle
// against a schedule-based model of window, step, in_ready and the result queue.
module tb_replicated_window_feeder;
    localparam int R   = 3;
    localparam int DEP = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic [7:0] result_in = 8'h00;

    logic           in_ready_o  [2];
    logic           step_o      [2];
    logic           out_valid_o [2];
    logic           primed_o    [2];
    logic [7:0]     out_byte_o  [2];
    logic [8*R-1:0] window_o    [2];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    replicated_window_feeder #(.REPLICATION_FACTOR(R), .RESULT_DELAY(0), .OUT_DEPTH(DEP)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .in_byte(in_byte), .flush(flush), .window(window_o[0]), .step(step_o[0]),
        .result_in(result_in), .out_valid(out_valid_o[0]), .out_ready(out_ready),
        .out_byte(out_byte_o[0]), .primed(primed_o[0])
    );

    replicated_window_feeder #(.REPLICATION_FACTOR(R), .RESULT_DELAY(2), .OUT_DEPTH(DEP)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .in_byte(in_byte), .flush(flush), .window(window_o[1]), .step(step_o[1]),
        .result_in(result_in), .out_valid(out_valid_o[1]), .out_ready(out_ready),
        .out_byte(out_byte_o[1]), .primed(primed_o[1])
    );

    // Reference state: last R bytes, bytes since flush, capture schedule, result queue.
    bit         m_started [2];
    int         m_cnt     [2];
    logic [7:0] m_hist    [2][R];
    bit         m_due     [2][8];
    bit         m_step    [2];
    logic [7:0] m_fifo    [2][8];
    int         m_fh      [2];
    int         m_fn      [2];

    logic [7:0] got0[$];
    int         obs_acc0;

    function automatic int dly(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_started[i] = 1'b0;
        m_cnt[i]     = 0;
        m_step[i]    = 1'b0;
        m_fh[i]      = 0;
        m_fn[i]      = 0;
        for (int k = 0; k < R; k++) m_hist[i][k] = 8'h00;
        for (int k = 0; k < 8; k++) m_due[i][k] = 1'b0;
    endtask

    function automatic int model_pending(input int i);
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(m_due[i][k]);
        return n;
    endfunction

    function automatic logic model_in_ready(input int i);
        return m_started[i] && !flush && (m_cnt[i] < R || (m_fn[i] + model_pending(i)) < DEP);
    endfunction

    function automatic logic [8*R-1:0] model_window(input int i);
        logic [8*R-1:0] w = '0;
        for (int k = 0; k < R; k++) w[8*k +: 8] = m_hist[i][k];
        return w;
    endfunction

    task automatic model_edge(input int i);
        logic acc;
        if (!reset) begin
            model_reset(i);
        end else begin
            acc = in_valid && model_in_ready(i);
            if (m_fn[i] > 0 && out_ready) begin
                m_fh[i] = (m_fh[i] + 1) % 8;
                m_fn[i]--;
            end
            if (m_due[i][0]) begin
                m_fifo[i][(m_fh[i] + m_fn[i]) % 8] = result_in;
                m_fn[i]++;
            end
            for (int k = 0; k < 7; k++) m_due[i][k] = m_due[i][k+1];
            m_due[i][7] = 1'b0;
            m_step[i] = 1'b0;
            if (flush) begin
                m_cnt[i] = 0;
                for (int k = 0; k < R; k++) m_hist[i][k] = 8'h00;
            end else if (acc) begin
                for (int k = R - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = in_byte;
                if (m_cnt[i] < R) m_cnt[i]++;
                if (m_cnt[i] == R) begin
                    m_step[i] = 1'b1;
                    m_due[i][dly(i)] = 1'b1;
                end
            end
            m_started[i] = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), 32'(in_ready_o[i]), 32'(model_in_ready(i)));
            chk($sformatf("primed[%0d]", i), 32'(primed_o[i]), 32'(m_cnt[i] == R));
            chk($sformatf("step[%0d]", i), 32'(step_o[i]), 32'(m_step[i]));
            chk($sformatf("window[%0d]", i), 32'(window_o[i]), 32'(model_window(i)));
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid_o[i]), 32'(m_fn[i] > 0));
            chk($sformatf("out_byte[%0d]", i), 32'(out_byte_o[i]),
                32'((m_fn[i] > 0) ? m_fifo[i][m_fh[i]] : 8'h00));
        end
        obs_acc0 = int'(in_valid && in_ready_o[0]);
        if (out_valid_o[0] && out_ready) got0.push_back(out_byte_o[0]);
        for (int i = 0; i < 2; i++) model_edge(i);
        @(posedge clock);
        #1;
        result_in = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!done && n < 50) begin
            cycle();
            done = (obs_acc0 != 0);
            n++;
        end
        chk("send_accept", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] r1;
        logic [7:0] r2;
        int n;
        for (int i = 0; i < 2; i++) model_reset(i);

        repeat (3) cycle();
        chk("rst_out_valid", 32'(out_valid_o[0]), 32'd0);
        chk("rst_window", 32'(window_o[0]), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o[0]), 32'd0);
        reset = 1'b1;
        cycle();
        got0.delete();

        // Fill and first two processed windows
        out_ready = 1'b1;
        send(8'h11);
        chk("fill1_step", 32'(step_o[0]), 32'd0);
        send(8'h22);
        chk("fill2_step", 32'(step_o[0]), 32'd0);
        send(8'h33);
        chk("s1_step", 32'(step_o[0]), 32'd1);
        chk("s1_window", 32'(window_o[0]), 32'h112233);
        chk("s1_primed", 32'(primed_o[0]), 32'd1);
        r1 = result_in;
        send(8'h44);
        chk("s2_step", 32'(step_o[0]), 32'd1);
        chk("s2_window", 32'(window_o[0]), 32'h223344);
        r2 = result_in;
        repeat (4) cycle();
        chk("s2_count", 32'(got0.size()), 32'd2);
        chk("s2_first", 32'(got0[0]), 32'(r1));
        chk("s2_second", 32'(got0[1]), 32'(r2));

        // Back-pressure: two queued results stop the input
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_primed", 32'(primed_o[0]), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        repeat (12) begin
            in_byte = 8'($urandom);
            cycle();
            n += obs_acc0;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(n), 32'd4);
        chk("bp_in_ready", 32'(in_ready_o[0]), 32'd0);
        got0.delete();
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("drain_count", 32'(got0.size()), 32'd2);
        chk("drain_in_ready", 32'(in_ready_o[0]), 32'd1);

        // Flush while primed with one result queued
        out_ready = 1'b0;
        send(8'h55);
        cycle();
        chk("fq_out_valid", 32'(out_valid_o[0]), 32'd1);
        in_valid = 1'b1;
        in_byte  = 8'h66;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fq_window", 32'(window_o[0]), 32'd0);
        chk("fq_primed", 32'(primed_o[0]), 32'd0);
        chk("fq_kept", 32'(out_valid_o[0]), 32'd1);
        got0.delete();
        out_ready = 1'b1;
        cycle();
        chk("fq_delivered", 32'(got0.size()), 32'd1);
        send(8'hA1);
        chk("rf1_step", 32'(step_o[0]), 32'd0);
        send(8'hA2);
        chk("rf2_step", 32'(step_o[0]), 32'd0);
        send(8'hA3);
        chk("rf3_step", 32'(step_o[0]), 32'd1);
        chk("rf3_window", 32'(window_o[0]), 32'hA1A2A3);

        // Random traffic
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_byte   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 29) == 0);
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        // Asynchronous reset with a full FIFO
        out_ready = 1'b1;
        repeat (4) cycle();
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        while (m_fn[0] != 2 && n < 30) begin
            in_byte = 8'($urandom);
            cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("mr_full_valid", 32'(out_valid_o[0]), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        #1;
        chk("mr_out_valid", 32'(out_valid_o[0]), 32'd0);
        chk("mr_window", 32'(window_o[0]), 32'd0);
        chk("mr_window2", 32'(window_o[1]), 32'd0);
        chk("mr_step", 32'(step_o[0]), 32'd0);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("mr_in_ready", 32'(in_ready_o[0]), 32'd1);
        chk("mr_primed", 32'(primed_o[0]), 32'd0);
        out_ready = 1'b1;
        send(8'h01);
        chk("mr1_step", 32'(step_o[0]), 32'd0);
        send(8'h02);
        chk("mr2_step", 32'(step_o[0]), 32'd0);
        send(8'h03);
        chk("mr3_step", 32'(step_o[0]), 32'd1);
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
